// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops one 16-bit FIFO word and sends it as two 8N1/8E1 frames, low byte first.
// Define UART_TX_PARITY_EN to build the even-parity option selected by control[1].
module uart_tx_engine #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      tx_fifo_rdata,
    input  logic             tx_fifo_empty,
    output logic             tx_fifo_rd,
    input  logic [1:0]       control,
    input  logic [DIV_W-1:0] baud,
    output logic [3:0]       tx_state,
    output logic             uart_tx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e           state_q, state_d;
    logic [15:0]      word_q, word_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             byte_q, byte_d;
    logic             par_q, par_d;
    logic             rd_q, rd_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic [7:0]       byte_sel;

`ifndef UART_TX_PARITY_EN
    logic unused_par_en;
    assign unused_par_en = control[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
            par_q   <= 1'b0;
            rd_q    <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            par_q   <= par_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
        end
    end

    assign bit_end = (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        par_d    = par_q;
        rd_d     = 1'b0;
        tx_d     = 1'b1;
        byte_sel = '0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (control[0] && (baud != '0) && !tx_fifo_empty) begin
                    rd_d    = 1'b1;
                    word_d  = tx_fifo_rdata;
                    div_d   = baud;
`ifdef UART_TX_PARITY_EN
                    par_d   = control[1];
`else
                    par_d   = 1'b0;
`endif
                    byte_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!byte_q) begin
                        byte_d  = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered: derive it from the state/bit being entered.
        byte_sel = byte_d ? word_d[15:8] : word_d[7:0];
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_sel[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^byte_sel;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_fifo_rd = rd_q;
    assign uart_tx    = tx_q;
    assign tx_state   = {1'b0, par_q, tx_fifo_empty, (state_q != IDLE)};

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a serial monitor decodes uart_tx.
module tb_uart_tx_engine;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   rdata;
    logic          empty;
    logic          rd;
    logic [1:0]    control;
    logic [DW-1:0] baud;
    logic [3:0]    st;
    logic          utx;

    always #5 clk = ~clk;

    uart_tx_engine #(.DIV_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .tx_fifo_rdata(rdata), .tx_fifo_empty(empty),
        .tx_fifo_rd(rd), .control(control), .baud(baud), .tx_state(st), .uart_tx(utx)
    );

    logic [15:0] fifo_mem [0:15];
    logic [3:0]  wr_ptr = '0;
    logic [3:0]  rd_ptr = '0;
    int          pops = 0;
    assign rdata = fifo_mem[rd_ptr];
    assign empty = (wr_ptr == rd_ptr);
    always @(posedge clk) if (rd) begin rd_ptr <= rd_ptr + 4'd1; pops <= pops + 1; end

    typedef struct {
        logic [7:0]  data;
        int unsigned baud;
        bit          has_par;
        bit          par;
        bit          second;
        bit          ignore;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fifo_push(input logic [15:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic expect_word(input logic [15:0] w, input int unsigned b, input bit hp,
                               input bit p0, input bit p1);
        exp_q.push_back('{data: w[7:0],  baud: b, has_par: hp, par: p0, second: 1'b0, ignore: 1'b0});
        exp_q.push_back('{data: w[15:8], baud: b, has_par: hp, par: p1, second: 1'b1, ignore: 1'b0});
    endtask

    task automatic monitor();
        exp_t e;
        time  t_fall;
        time  t_prev = 0;
        logic [7:0] d;
        forever begin
            @(negedge utx);
            t_fall = $time;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                continue;
            end
            e = exp_q.pop_front();
            if (e.ignore) begin
                for (int i = 0; i < 1000 && rst_n; i++) @(negedge clk);
                check("abort_frame_reset", {31'd0, rst_n}, 32'd0);
                continue;
            end
            if (e.second)
                check("byte_gap_time", 32'(t_fall - t_prev), (e.has_par ? 32'd11 : 32'd10) * e.baud * 32'd10);
            t_prev = t_fall;
            repeat (e.baud / 2 + 1) @(negedge clk);
            check("start_bit", {31'd0, utx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (e.baud) @(negedge clk);
                d[i] = utx;
            end
            check("data_byte", {24'd0, d}, {24'd0, e.data});
            if (e.has_par) begin
                repeat (e.baud) @(negedge clk);
                check("parity_bit", {31'd0, utx}, {31'd0, e.par});
            end
            repeat (e.baud) @(negedge clk);
            check("stop_bit", {31'd0, utx}, 32'd1);
        end
    endtask

    // Waits for busy, optionally changes control/baud after `at` busy cycles, then checks word length.
    task automatic wait_word(input string name, input int exp_n, input int at,
                             input logic [1:0] ctl, input logic [DW-1:0] bd);
        int n = 0;
        int w = 0;
        while (!st[0] && w < 20) begin @(negedge clk); w++; end
        check({name, "_started"}, {31'd0, st[0]}, 32'd1);
        while (st[0] && n < 2000) begin
            n++;
            if (n == at) begin control = ctl; baud = bd; end
            @(negedge clk);
        end
        check({name, "_duration"}, n, exp_n);
    endtask

    int p0;
    int bad;

    initial begin
        rst_n = 1'b0; control = 2'b00; baud = '0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'd0, utx}, 32'd1);
        check("rst_fifo_rd", {31'd0, rd}, 32'd0);
        check("rst_state", {28'd0, st}, 32'h2);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x4155 at baud 4, 8N1
        control = 2'b01; baud = 16'd4; p0 = pops;
        fifo_push(16'h4155); expect_word(16'h4155, 4, 1'b0, 1'b0, 1'b0);
        wait_word("w4155", 80, -1, 2'b01, 16'd4);
        check("w4155_pops", pops - p0, 1);
        check("w4155_idle_state", {28'd0, st}, 32'h2);

`ifdef UART_TX_PARITY_EN
        control = 2'b11; baud = 16'd3;
        fifo_push(16'h0307); expect_word(16'h0307, 3, 1'b1, 1'b1, 1'b0);
        wait_word("w0307_par", 66, -1, 2'b11, 16'd3);
        check("w0307_par_active", {31'd0, st[2]}, 32'd1);
`else
        control = 2'b11; baud = 16'd3;
        fifo_push(16'h0307); expect_word(16'h0307, 3, 1'b0, 1'b0, 1'b0);
        wait_word("w0307_nopar", 60, -1, 2'b11, 16'd3);
        check("w0307_par_active", {31'd0, st[2]}, 32'd0);
`endif

        // baud=0 then tx_en=0 with a non-empty FIFO: nothing may happen
        control = 2'b01; baud = '0; p0 = pops; bad = 0;
        fifo_push(16'h1234); expect_word(16'h1234, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin control = 2'b00; baud = 16'd2; end
            @(negedge clk);
            if (utx !== 1'b1 || rd !== 1'b0) bad++;
        end
        check("disabled_line_quiet", bad, 0);
        check("disabled_no_pop", pops - p0, 0);
        control = 2'b01;
        @(negedge clk);
        check("enable_rd_1clk", {31'd0, rd}, 32'd1);
        check("enable_tx_low_1clk", {31'd0, utx}, 32'd0);
        wait_word("w1234", 40, -1, 2'b01, 16'd2);

        // tx_en cleared during byte 0 of the first of two words
        control = 2'b01; baud = 16'd4; p0 = pops;
        fifo_push(16'hA5C3); fifo_push(16'h0F1E); expect_word(16'hA5C3, 4, 1'b0, 1'b0, 1'b0);
        wait_word("wA5C3", 80, 5, 2'b00, 16'd4);
        repeat (30) @(negedge clk);
        check("txen_off_pops", pops - p0, 1);
        check("txen_off_state", {28'd0, st}, 32'h0);
        check("txen_off_line", {31'd0, utx}, 32'd1);

        // baud 4 -> 8 mid-word applies to the next word only
        p0 = pops;
        expect_word(16'h0F1E, 4, 1'b0, 1'b0, 1'b0);
        fifo_push(16'h8001); expect_word(16'h8001, 8, 1'b0, 1'b0, 1'b0);
        control = 2'b01;
        wait_word("w0F1E", 80, 10, 2'b01, 16'd8);
        wait_word("w8001", 160, -1, 2'b01, 16'd8);
        check("baud_chg_pops", pops - p0, 2);

        // reset mid-DATA
        baud = 16'd4;
        exp_q.push_back('{data: 8'h00, baud: 4, has_par: 1'b0, par: 1'b0, second: 1'b0, ignore: 1'b1});
        fifo_push(16'h6699);
        bad = 0;
        while (!st[0] && bad < 20) begin @(negedge clk); bad++; end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_line", {31'd0, utx}, 32'd1);
        check("midrst_busy", {31'd0, st[0]}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fifo_push(16'h3C5A); expect_word(16'h3C5A, 4, 1'b0, 1'b0, 1'b0);
        wait_word("w3C5A", 80, -1, 2'b01, 16'd4);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("total_pops", pops, 8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
